// File: rtl/pe_sequencer_pkg.sv
// Shared types for the PE sequencer: FSM state encoding, default data width, PE control bundle.
package pe_pkg;
   localparam int PE_DW = 32;

   typedef enum logic [2:0] {
      ST_LOAD_A,
      ST_LOAD_B,
      ST_CLEAR,
      ST_MAC,
      ST_CAPTURE,
      ST_RESULT
   } pe_seq_state_t;

   typedef struct packed {
      logic write_mat;
      logic mat_mux;
      logic rst_mul;
      logic mac_ctrl;
      logic inc_pc;
   } pe_ctrl_t;
endpackage

// File: rtl/pe_sequencer_if.sv
// Bundles the operand stream, result stream and PE lane signals of the sequencer.
interface pe_sequencer_if
   import pe_pkg::*;
#(
   parameter int N  = 16,
   parameter int DW = PE_DW
) ();
   localparam int PCW = $clog2(N);

   logic            VEC_VALID;
   logic            VEC_READY;
   logic [N*DW-1:0] VEC_DATA;

   logic [N*DW-1:0] PE_DATAIN;
   logic            PE_WRITE_MAT;
   logic            PE_MAT_MUX;
   logic            PE_RST_MUL;
   logic            PE_MAC_CTRL;
   logic            PE_INC_PC;
   logic [PCW-1:0]  PE_PC_COUNTER;
   logic [DW-1:0]   PE_DATAOUT;

   logic            RES_VALID;
   logic            RES_READY;
   logic [DW-1:0]   RES_DATA;

   modport master (
      input  VEC_VALID, VEC_DATA, PE_PC_COUNTER, PE_DATAOUT, RES_READY,
      output VEC_READY, PE_DATAIN, PE_WRITE_MAT, PE_MAT_MUX, PE_RST_MUL,
             PE_MAC_CTRL, PE_INC_PC, RES_VALID, RES_DATA
   );

   modport slave (
      output VEC_VALID, VEC_DATA, PE_PC_COUNTER, PE_DATAOUT, RES_READY,
      input  VEC_READY, PE_DATAIN, PE_WRITE_MAT, PE_MAT_MUX, PE_RST_MUL,
             PE_MAC_CTRL, PE_INC_PC, RES_VALID, RES_DATA
   );
endinterface

// File: rtl/pe_sequencer.sv
// Loads A/B operand vectors into one PE lane, runs clear + N MAC cycles, returns the dot product.
// Optional PE_SEQ_PC_CHECK_EN: internal PC cross-check with sticky ERR and self-timed termination.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_LOAD_A  | idle, accept A vector (PE_MAT_MUX=1)
// ST_LOAD_B  | accept B vector (PE_MAT_MUX=0)
// ST_CLEAR   | one-cycle PE PC/accumulator clear
// ST_MAC     | accumulate, advance PE PC until last element
// ST_CAPTURE | latch PE accumulator into RES_DATA
// ST_RESULT  | present result until consumer handshake
module pe_sequencer
   import pe_pkg::*;
#(
   parameter int N  = 16,
   parameter int DW = PE_DW
) (
   input  logic           CLK,
   input  logic           RSTN,
   pe_sequencer_if.master bus,
   output logic           BUSY,
   output logic           ERR
);
   localparam int PCW = $clog2(N);
   localparam logic [PCW-1:0] PC_LAST = PCW'(N - 1);

   pe_seq_state_t state, state_nxt;
   pe_ctrl_t      ctrl;
   logic          vec_ready;
   logic          res_valid;
   logic          mac_last;
   logic [DW-1:0] res_data;

`ifdef PE_SEQ_PC_CHECK_EN
   logic [PCW-1:0] pc_exp;
   logic           err_q;

   // Termination follows our own count so a stuck PE PC cannot hang the job.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         pc_exp <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == ST_CLEAR) pc_exp <= '0;
         else if (state == ST_MAC) pc_exp <= pc_exp + 1'b1;
         if (state == ST_MAC && bus.PE_PC_COUNTER != pc_exp) err_q <= 1'b1;
      end
   end

   assign mac_last = (pc_exp == PC_LAST);
   assign ERR      = err_q;
`else
   assign mac_last = (bus.PE_PC_COUNTER == PC_LAST);
   assign ERR      = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= ST_LOAD_A;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_LOAD_A:  if (bus.VEC_VALID) state_nxt = ST_LOAD_B;
         ST_LOAD_B:  if (bus.VEC_VALID) state_nxt = ST_CLEAR;
         ST_CLEAR:   state_nxt = ST_MAC;
         ST_MAC:     if (mac_last) state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_RESULT;
         ST_RESULT:  if (bus.RES_READY) state_nxt = ST_LOAD_A;
         default:    state_nxt = ST_LOAD_A;
      endcase
   end

   always_comb begin
      ctrl      = '0;
      vec_ready = 1'b0;
      res_valid = 1'b0;
      unique case (state)
         ST_LOAD_A: begin
            vec_ready      = 1'b1;
            ctrl.mat_mux   = 1'b1;
            ctrl.write_mat = bus.VEC_VALID;
         end
         ST_LOAD_B: begin
            vec_ready      = 1'b1;
            ctrl.write_mat = bus.VEC_VALID;
         end
         ST_CLEAR: ctrl.rst_mul = 1'b1;
         ST_MAC: begin
            ctrl.mac_ctrl = 1'b1;
            ctrl.inc_pc   = 1'b1;
         end
         ST_RESULT: res_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                   res_data <= '0;
      else if (state == ST_CAPTURE) res_data <= bus.PE_DATAOUT;
   end

   assign bus.VEC_READY    = vec_ready;
   assign bus.PE_DATAIN    = bus.VEC_DATA;
   assign bus.PE_WRITE_MAT = ctrl.write_mat;
   assign bus.PE_MAT_MUX   = ctrl.mat_mux;
   assign bus.PE_RST_MUL   = ctrl.rst_mul;
   assign bus.PE_MAC_CTRL  = ctrl.mac_ctrl;
   assign bus.PE_INC_PC    = ctrl.inc_pc;
   assign bus.RES_VALID    = res_valid;
   assign bus.RES_DATA     = res_data;
   assign BUSY             = (state != ST_LOAD_A);
endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer (N=4) with a behavioural PE lane and a dot-product reference.
module tb_pe_sequencer;
   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int PCW = $clog2(N);

   typedef logic [DW-1:0] vec_t [N];

   logic CLK = 1'b0;
   logic RSTN;
   logic busy, err;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 CLK = ~CLK;

   pe_sequencer_if #(.N(N), .DW(DW)) bus ();

   pe_sequencer #(.N(N), .DW(DW)) dut (
      .CLK (CLK),
      .RSTN(RSTN),
      .bus (bus),
      .BUSY(busy),
      .ERR (err)
   );

   // Behavioural PE lane: registered PC and accumulator, combinational product, no reset.
   logic [N*DW-1:0] pe_a   = '0;
   logic [N*DW-1:0] pe_b   = '0;
   logic [PCW-1:0]  pe_pc  = '0;
   logic [DW-1:0]   pe_acc = '0;
   logic [DW-1:0]   pe_prod;
   bit              stuck_pc = 1'b0;

   always_comb pe_prod = pe_a[int'(pe_pc)*DW +: DW] * pe_b[int'(pe_pc)*DW +: DW];

   always @(posedge CLK) begin
      if (bus.PE_WRITE_MAT) begin
         if (bus.PE_MAT_MUX) pe_a <= bus.PE_DATAIN;
         else                pe_b <= bus.PE_DATAIN;
      end
      if (bus.PE_RST_MUL) begin
         pe_pc  <= '0;
         pe_acc <= '0;
      end else begin
         if (bus.PE_MAC_CTRL) pe_acc <= pe_acc + pe_prod;
         if (bus.PE_INC_PC && !stuck_pc) pe_pc <= pe_pc + 1'b1;
      end
   end

   assign bus.PE_PC_COUNTER = pe_pc;
   assign bus.PE_DATAOUT    = pe_acc;

   function automatic logic [N*DW-1:0] pack(input vec_t v);
      logic [N*DW-1:0] p;
      for (int i = 0; i < N; i++) p[i*DW +: DW] = v[i];
      return p;
   endfunction

   function automatic logic [DW-1:0] dot_ref(input vec_t a, input vec_t b);
      logic [63:0] s;
      s = 64'd0;
      for (int i = 0; i < N; i++) s = s + 64'(a[i]) * 64'(b[i]);
      return s[DW-1:0];
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < N; i++)
         v[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 255));
      return v;
   endfunction

   // Runs one full job starting at a negedge in LOAD_A; returns at a negedge after the result handshake.
   task automatic do_job(input vec_t a, input vec_t b, input int hold, input bit extra,
                         output logic [DW-1:0] res, output int lat, output int rst_cnt,
                         output int viol, output bit tmo, output int err_first, output time t_a);
      int n;
      res = '0; lat = 0; rst_cnt = 0; viol = 0; tmo = 1'b0; err_first = -1; n = 0;
      bus.RES_READY = (hold == 0);
      while (busy && n < 200) begin
         @(posedge CLK); @(negedge CLK); n++;
      end
      if (busy) tmo = 1'b1;
      bus.VEC_VALID = 1'b1;
      bus.VEC_DATA  = pack(a);
      #1;
      if (!bus.VEC_READY || !bus.PE_WRITE_MAT || !bus.PE_MAT_MUX) viol++;
      @(posedge CLK); t_a = $time;
      @(negedge CLK);
      bus.VEC_DATA = pack(b);
      #1;
      if (!bus.VEC_READY || !bus.PE_WRITE_MAT || bus.PE_MAT_MUX) viol++;
      @(posedge CLK);
      @(negedge CLK);
      bus.VEC_VALID = extra;
      bus.VEC_DATA  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n = 0;
      while (!bus.RES_VALID && n < 100) begin
         if (bus.PE_RST_MUL) rst_cnt++;
         if (bus.PE_WRITE_MAT || bus.VEC_READY) viol++;
         if (err && err_first < 0) err_first = n;
         @(posedge CLK); @(negedge CLK); #1; n++;
      end
      lat = n;
      if (!bus.RES_VALID) tmo = 1'b1;
      res = bus.RES_DATA;
      for (int i = 0; i < hold; i++) begin
         if (!bus.RES_VALID || bus.RES_DATA !== res || bus.VEC_READY || bus.PE_WRITE_MAT) viol++;
         @(posedge CLK); @(negedge CLK); #1;
      end
      bus.RES_READY = 1'b1;
      bus.VEC_VALID = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      bus.VEC_VALID = 1'b0; bus.VEC_DATA = '0; bus.RES_READY = 1'b0;
      #12;
      tests_run++;
      if ({bus.RES_VALID, busy, err, bus.PE_WRITE_MAT, bus.PE_RST_MUL, bus.PE_MAC_CTRL, bus.PE_INC_PC} !== 7'b0) begin
         tests_failed++; $display("FAIL reset_outs got=%b want=0000000",
            {bus.RES_VALID, busy, err, bus.PE_WRITE_MAT, bus.PE_RST_MUL, bus.PE_MAC_CTRL, bus.PE_INC_PC});
      end
      tests_run++;
      if (bus.RES_DATA !== '0) begin
         tests_failed++; $display("FAIL reset_res_data got=%0h want=0", bus.RES_DATA);
      end
      @(negedge CLK); RSTN = 1'b1;
      @(negedge CLK); #1;
      tests_run++;
      if (bus.VEC_READY !== 1'b1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_release ready=%b busy=%b want 1/0", bus.VEC_READY, busy);
      end
      @(negedge CLK);
   endtask

   task automatic test_basic();
      vec_t a, b; logic [DW-1:0] r; int lat, rc, viol, ef; bit tmo; time t;
      a = '{32'd1, 32'd2, 32'd3, 32'd4};
      b = '{32'd5, 32'd6, 32'd7, 32'd8};
      do_job(a, b, 0, 1'b0, r, lat, rc, viol, tmo, ef, t);
      tests_run++; if (r !== 32'd70) begin tests_failed++; $display("FAIL basic_result got=%0d want=70", r); end
      tests_run++; if (lat != N + 2) begin tests_failed++; $display("FAIL basic_latency got=%0d want=%0d", lat, N + 2); end
      tests_run++; if (rc != 1) begin tests_failed++; $display("FAIL basic_rst_pulse got=%0d want=1", rc); end
      tests_run++; if (viol != 0 || tmo) begin tests_failed++; $display("FAIL basic_protocol viol=%0d tmo=%0b want 0/0", viol, tmo); end
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL basic_err got=%b want=0", err); end
   endtask

   task automatic test_backpressure();
      vec_t a, b; logic [DW-1:0] r; int lat, rc, viol, ef; bit tmo; time t;
      a = '{32'd1, 32'd2, 32'd3, 32'd4};
      b = '{32'd5, 32'd6, 32'd7, 32'd8};
      do_job(a, b, 5, 1'b1, r, lat, rc, viol, tmo, ef, t);
      tests_run++; if (r !== 32'd70) begin tests_failed++; $display("FAIL bp_result got=%0d want=70", r); end
      tests_run++; if (viol != 0 || tmo) begin tests_failed++; $display("FAIL bp_hold viol=%0d tmo=%0b want 0/0", viol, tmo); end
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_extra_consumed busy=%b want=0", busy); end
   endtask

   task automatic test_wrap();
      vec_t a; logic [DW-1:0] r; int lat, rc, viol, ef; bit tmo; time t;
      a = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
      do_job(a, a, 0, 1'b0, r, lat, rc, viol, tmo, ef, t);
      tests_run++; if (r !== 32'd0) begin tests_failed++; $display("FAIL wrap_result got=%0h want=0", r); end
   endtask

   task automatic test_back_to_back();
      vec_t a1, b1, a2, b2; logic [DW-1:0] r1, r2; int lat, rc, viol, ef; bit tmo; time t1, t2;
      a1 = '{32'd1, 32'd1, 32'd1, 32'd1}; b1 = '{32'd2, 32'd2, 32'd2, 32'd2};
      a2 = '{32'd3, 32'd3, 32'd3, 32'd3}; b2 = '{32'd1, 32'd0, 32'd0, 32'd1};
      do_job(a1, b1, 0, 1'b0, r1, lat, rc, viol, tmo, ef, t1);
      do_job(a2, b2, 0, 1'b0, r2, lat, rc, viol, tmo, ef, t2);
      tests_run++; if (r1 !== 32'd8) begin tests_failed++; $display("FAIL b2b_first got=%0d want=8", r1); end
      tests_run++; if (r2 !== 32'd6) begin tests_failed++; $display("FAIL b2b_second got=%0d want=6", r2); end
      tests_run++;
      if ((t2 - t1) / 10 != N + 5) begin
         tests_failed++; $display("FAIL b2b_period got=%0d want=%0d", (t2 - t1) / 10, N + 5);
      end
   endtask

   task automatic test_random();
      vec_t a, b; logic [DW-1:0] r, exp; int lat, rc, viol, ef; bit tmo; time t;
      for (int k = 0; k < 8; k++) begin
         a = rand_vec(); b = rand_vec(); exp = dot_ref(a, b);
         do_job(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, lat, rc, viol, tmo, ef, t);
         tests_run++;
         if (r !== exp) begin tests_failed++; $display("FAIL rand_result[%0d] got=%0h want=%0h", k, r, exp); end
         tests_run++;
         if (lat != N + 2 || viol != 0 || tmo) begin
            tests_failed++; $display("FAIL rand_timing[%0d] lat=%0d viol=%0d tmo=%0b want %0d/0/0", k, lat, viol, tmo, N + 2);
         end
      end
   endtask

   task automatic test_reset_mid_job();
      vec_t a, b; logic [DW-1:0] r; int lat, rc, viol, ef; bit tmo; time t;
      a = '{32'd9, 32'd8, 32'd7, 32'd6}; b = '{32'd1, 32'd2, 32'd3, 32'd4};
      bus.VEC_VALID = 1'b1; bus.VEC_DATA = pack(a);
      @(posedge CLK); @(negedge CLK); bus.VEC_DATA = pack(b);
      @(posedge CLK); @(negedge CLK); bus.VEC_VALID = 1'b0;
      @(posedge CLK); @(negedge CLK);
      @(posedge CLK); @(negedge CLK);
      #1;
      tests_run++;
      if (bus.PE_MAC_CTRL !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_mac got=%b want=1", bus.PE_MAC_CTRL); end
      RSTN = 1'b0;
      #1;
      tests_run++;
      if ({busy, bus.RES_VALID, err, bus.PE_MAC_CTRL, bus.PE_INC_PC, bus.PE_RST_MUL, bus.PE_WRITE_MAT} !== 7'b0) begin
         tests_failed++; $display("FAIL midrst_outs got=%b want=0000000",
            {busy, bus.RES_VALID, err, bus.PE_MAC_CTRL, bus.PE_INC_PC, bus.PE_RST_MUL, bus.PE_WRITE_MAT});
      end
      tests_run++;
      if (bus.RES_DATA !== '0) begin tests_failed++; $display("FAIL midrst_res_data got=%0h want=0", bus.RES_DATA); end
      @(negedge CLK); RSTN = 1'b1;
      @(negedge CLK); #1;
      tests_run++;
      if (bus.VEC_READY !== 1'b1) begin tests_failed++; $display("FAIL midrst_ready got=%b want=1", bus.VEC_READY); end
      @(negedge CLK);
      do_job(a, b, 0, 1'b0, r, lat, rc, viol, tmo, ef, t);
      tests_run++;
      if (r !== dot_ref(a, b)) begin tests_failed++; $display("FAIL midrst_recover got=%0d want=%0d", r, dot_ref(a, b)); end
   endtask

`ifdef PE_SEQ_PC_CHECK_EN
   task automatic test_pc_check();
      vec_t a, b; logic [DW-1:0] r; int lat, rc, viol, ef; bit tmo; time t;
      a = rand_vec(); b = rand_vec();
      stuck_pc = 1'b1;
      do_job(a, b, 0, 1'b0, r, lat, rc, viol, tmo, ef, t);
      stuck_pc = 1'b0;
      tests_run++; if (ef != 3) begin tests_failed++; $display("FAIL pcchk_err_time got=%0d want=3", ef); end
      tests_run++; if (lat != N + 2 || tmo) begin tests_failed++; $display("FAIL pcchk_terminate lat=%0d tmo=%0b want %0d/0", lat, tmo, N + 2); end
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL pcchk_sticky got=%b want=1", err); end
      RSTN = 1'b0; #1;
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL pcchk_clear got=%b want=0", err); end
      @(negedge CLK); RSTN = 1'b1; @(negedge CLK);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid_job();
`ifdef PE_SEQ_PC_CHECK_EN
      test_pc_check();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Control-side initiator for one processing element (PE). Accepts two N-element operand vectors over a valid/ready stream, loads them into the PE's A and B matrix registers, and sequences the clear and multiply-accumulate phases. Captures the dot product and returns it on a valid/ready result port. Sits between the vector fetch logic and a single PE lane, driving every PE control input and consuming its PC and accumulator outputs.

## Interface

- N, 16: elements per vector; power of two, ≥2; sets PE PC width $clog2(N)
- DW, 32: element and result width
- CLK  in  1  clock, all logic rising-edge
- RSTN  in  1  one clock; reset is asynchronous and active-low
- VEC_VALID  in  1  operand vector present
- VEC_READY  out  1  sequencer accepts a vector this cycle
- VEC_DATA  in  N×DW  packed operand vector
- PE_DATAIN  out  N×DW  vector to PE; combinational copy of VEC_DATA
- PE_WRITE_MAT  out  1  PE matrix write strobe
- PE_MAT_MUX  out  1  1 selects A, 0 selects B
- PE_RST_MUL  out  1  clears PE PC and accumulator at next edge
- PE_MAC_CTRL  out  1  PE accumulate enable
- PE_INC_PC  out  1  PE PC increment
- PE_PC_COUNTER  in  $clog2(N)  PE element index
- PE_DATAOUT  in  DW  PE accumulator
- RES_VALID  out  1  result available
- RES_READY  in  1  result consumer ready
- RES_DATA  out  DW  captured dot product
- BUSY  out  1  high in every state except LOAD_A
- ERR  out  1  sticky PC-check error (see Configuration)

## Operation

- States: LOAD_A (reset state), LOAD_B, CLEAR, MAC, CAPTURE, RESULT.
- LOAD_A: VEC_READY=1, PE_MAT_MUX=1. Handshake (VEC_VALID&VEC_READY) → PE_WRITE_MAT=1 same cycle; next LOAD_B.
- LOAD_B: VEC_READY=1, PE_MAT_MUX=0. Handshake → PE_WRITE_MAT=1; next CLEAR.
- CLEAR: PE_RST_MUL=1 for exactly one cycle; next MAC.
- MAC: PE_MAC_CTRL=1, PE_INC_PC=1. Stays while PE_PC_COUNTER≠N-1; cycle with PE_PC_COUNTER==N-1 is the last accumulate → CAPTURE. PE PC wraps to 0 at that edge.
- CAPTURE: all PE controls 0; RES_DATA←PE_DATAOUT at the edge; next RESULT.
- RESULT: RES_VALID=1, RES_DATA stable. RES_VALID&RES_READY → LOAD_A.
- PE_WRITE_MAT, PE_RST_MUL, PE_MAC_CTRL, PE_INC_PC are 0 in every state not listed above for them.
- Arithmetic: result is PE accumulator value unchanged, modulo 2^DW; no saturation.
- VEC_VALID while not in LOAD_A/LOAD_B: ignored, not consumed.

## Timing

- Reset (RSTN low, asynchronous): state LOAD_A; VEC_READY=1 after release; RES_VALID=0, RES_DATA=0, BUSY=0, ERR=0, all PE controls 0.
- Reset mid-job: job discarded; PE not reset by sequencer; next job's CLEAR restores PE state.
- Latency: B handshake at edge e0 → CLEAR cycle → N MAC cycles → CAPTURE → RES_VALID high after edge e0+N+2.
- Job period with RES_READY tied 1: N+5 cycles minimum (A, B, CLEAR, N×MAC, CAPTURE, RESULT).
- Result handshake and new A accept never overlap: VEC_READY=0 throughout RESULT; LOAD_A follows the result edge.
- RES_VALID once high never drops until handshake or reset.

## Configuration

- PE_SEQ_PC_CHECK_EN defined: internal expected-index counter cleared in CLEAR, incremented each MAC cycle; any MAC cycle with PE_PC_COUNTER≠counter sets ERR (sticky until reset); termination then uses the internal counter reaching N-1, so a stuck PE PC cannot hang the FSM.
- Undefined: no counter; termination on PE_PC_COUNTER==N-1 only; ERR tied 0.

## Structure

- Shared package pe_pkg: state enum typedef pe_seq_state_t, DW default localparam, PE control struct if the PE array bundles controls.
- Single module; no sub-module needed.
- Bench supplies a behavioural PE model (registered PC, combinational product, registered accumulator).

## Test plan

- Reset: drive RSTN low during MAC → all outputs 0 immediately, VEC_READY=1 after release, ERR=0.
- N=4, A={1,2,3,4}, B={5,6,7,8}, RES_READY=1 → RES_DATA=70, RES_VALID rises 6 cycles after B handshake, one-cycle PE_RST_MUL pulse observed.
- Backpressure: same job, RES_READY low 5 cycles → RES_VALID=1, RES_DATA=70 held, VEC_READY=0, extra VEC_VALID not consumed.
- Wrap: N=4, all elements 0x00010000 → RES_DATA=0 (4×2^32 mod 2^32).
- Back-to-back: A={1,1,1,1}, B={2,2,2,2} then A={3,3,3,3}, B={1,0,0,1} → results 8 then 6, period 9 cycles.
- PE_SEQ_PC_CHECK_EN: PE model PC stuck at 0 → ERR=1 on second MAC cycle, FSM still reaches RESULT after 4 MAC cycles.
